clk_div_prog: RTL and testbench

- Multi-channel, runtime-programmable clock/tick divider.
- Successor to the fixed single-divisor divider; generates CHANNELS independent divided square waves plus one-cycle tick strobes from clk.
- Divisor reload is glitch-free, per channel: the new value takes effect only at a terminal count.
- Feeds display multiplexing, debounce sampling and slow-rate FSMs in the synthesis top.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 101 ++++++++++
 rtl/clk_div_prog.sv | 66 ++++++
 tb/tb_clk_div_prog.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
//   DEFAULT_CNT_W / DEFAULT_DIV : default counter width and reset divisor
//   ch_idx_w()                  : channel-index width, clog2 with a minimum of 1
// The per-channel state struct is declared inside clk_div_chan, because its
// field widths depend on that module's CNT_W parameter.
package clk_div_pkg;

  localparam int          DEFAULT_CNT_W = 26;
  localparam int unsigned DEFAULT_DIV   = 50_000_000;

  // A single channel still needs a 1-bit select.
  function automatic int ch_idx_w(input int n);
    if (n <= 2) return 1;
    else        return $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   clk, rst_n  : clock, async active-low reset
//   en          : run enable (level)
//   wr, wr_div  : accepted divisor write for this channel and its value
//   sync        : phase restart, present only with CLK_DIV_PROG_SYNC_EN
//   pending     : shadow divisor is waiting for a terminal count
//   clk_out     : divided square wave, period 2*(div_reg+1)
//   tick        : one-cycle strobe on every clk_out toggle
// Optional macro: CLK_DIV_PROG_SYNC_EN.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned RST_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_DIV_PROG_SYNC_EN
  input  logic             sync,
`endif
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             out;
    logic             tick;
  } chan_state_t;

  chan_state_t st, nxt;

  always_comb begin
    nxt      = st;
    nxt.tick = 1'b0;
    if (!en) begin
      nxt.cnt = '0;
      nxt.out = 1'b0;
      if (st.pending) begin
        nxt.div_reg = st.shadow;
        nxt.pending = 1'b0;
      end
      // Idle channel: no terminal count to wait for, load straight away.
      if (wr) nxt.div_reg = wr_div;
    end else begin
`ifdef CLK_DIV_PROG_SYNC_EN
      if (sync) begin
        nxt.cnt = '0;
        nxt.out = 1'b0;
        if (st.pending) begin
          nxt.div_reg = st.shadow;
          nxt.pending = 1'b0;
        end
      end else
`endif
      if (st.cnt == st.div_reg) begin
        nxt.cnt  = '0;
        nxt.out  = ~st.out;
        nxt.tick = 1'b1;
        // Reload only at wrap, so cnt never overshoots a smaller divisor.
        if (st.pending) begin
          nxt.div_reg = st.shadow;
          nxt.pending = 1'b0;
        end
      end else begin
        nxt.cnt = st.cnt + 1'b1;
      end
      // Evaluated after the reload: a write coinciding with a terminal
      // count waits for the following one.
      if (wr) begin
        nxt.shadow  = wr_div;
        nxt.pending = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st.cnt     <= '0;
      st.div_reg <= CNT_W'(RST_DIV);
      st.shadow  <= '0;
      st.pending <= 1'b0;
      st.out     <= 1'b0;
      st.tick    <= 1'b0;
    end else begin
      st <= nxt;
    end
  end

  assign pending = st.pending;
  assign clk_out = st.out;
  assign tick    = st.tick;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel runtime-programmable clock/tick divider.
//   clk, rst_n         : clock, async active-low reset
//   en[CHANNELS]       : per-channel run enable
//   cfg_valid/cfg_ready: divisor write handshake; cfg_ch selects the channel,
//                        cfg_div carries the value. Out-of-range cfg_ch is
//                        accepted and dropped.
//   sync               : global phase restart (effective only with
//                        CLK_DIV_PROG_SYNC_EN defined, otherwise ignored)
//   pending, clk_out, tick : per-channel status and outputs
// Optional macro: CLK_DIV_PROG_SYNC_EN.
module clk_div_prog #(
  parameter  int          CHANNELS    = 4,
  parameter  int          CNT_W       = clk_div_pkg::DEFAULT_CNT_W,
  parameter  int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
  localparam int          CH_W        = clk_div_pkg::ch_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                sync,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  import clk_div_pkg::*;

  localparam int NSLOT = 2 ** CH_W;

  // Zero-padded so unused select codes read as "not pending" -> ready.
  logic [NSLOT-1:0] pend_ext;
  assign pend_ext  = NSLOT'(pending);
  assign cfg_ready = ~pend_ext[cfg_ch];

`ifndef CLK_DIV_PROG_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[g]),
      .wr      (wr),
      .wr_div  (cfg_div),
`ifdef CLK_DIV_PROG_SYNC_EN
      .sync    (sync),
`endif
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for clk_div_prog (CHANNELS=4, CNT_W=8,
// DEFAULT_DIV=3). Expected values are hand-derived edge by edge; the sync
// section selects its expectations by CLK_DIV_PROG_SYNC_EN.
module tb_clk_div_prog;

`ifdef CLK_DIV_PROG_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       sync;
  logic [3:0] pending, clk_out, tick;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .CHANNELS    (4),
    .CNT_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .sync      (sync),
    .pending   (pending),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 4'hF; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
    step(2);
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ready",   32'(cfg_ready), 32'h1);
    rst_n = 1'b1;                                   // E0

    // Default divisor 3: toggle every 4 edges.
    step(3);  check("e3_clk_out", 32'(clk_out), 32'h0);
              check("e3_tick",    32'(tick),    32'h0);
    step(1);  check("e4_clk_out", 32'(clk_out), 32'hF);
              check("e4_tick",    32'(tick),    32'hF);
    step(1);  check("e5_tick",    32'(tick),    32'h0);
    step(3);  check("e8_clk_out", 32'(clk_out), 32'h0);
              check("e8_tick",    32'(tick),    32'hF);

    // ch1 <- 1 mid-period (cnt=1).
    step(1);                                        // E9
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
    #1 check("wr1_ready", 32'(cfg_ready), 32'h1);
    step(1);                                        // E10 accepted
    check("wr1_pending", 32'(pending), 32'h2);
    check("wr1_busy",    32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step(2);                                        // E12 old terminal count
    check("e12_pending", 32'(pending), 32'h0);
    check("e12_clk_out", 32'(clk_out), 32'hF);
    step(1);  check("e13_clk_out", 32'(clk_out), 32'hF);
              check("e13_tick",    32'(tick),    32'h0);
    step(1);  check("e14_clk_out", 32'(clk_out), 32'hD);
              check("e14_tick",    32'(tick),    32'h2);
    step(2);  check("e16_clk_out", 32'(clk_out), 32'h2);
              check("e16_tick",    32'(tick),    32'hF);

    // ch2 <- 5, then a second write while pending is refused.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5;
    step(1);                                        // E17 accepted
    check("wr2_pending", 32'(pending), 32'h4);
    cfg_div = 8'd7;
    #1 check("wr2_refused", 32'(cfg_ready), 32'h0);
    step(2);                                        // E19
    check("e19_pending", 32'(pending), 32'h4);
    cfg_valid = 1'b0;
    step(1);                                        // E20 reload div=5
    check("e20_pending", 32'(pending), 32'h0);
    check("e20_clk_out", 32'(clk_out), 32'hF);
    step(5);                                        // E25, ch2 cnt=5
    check("e25_ch2_out", 32'(clk_out[2]), 32'h1);
    check("e25_ch2_tick", 32'(tick[2]), 32'h0);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
    #1 check("wr2b_ready", 32'(cfg_ready), 32'h1);
    step(1);                                        // E26 terminal + write
    check("e26_ch2_tick", 32'(tick[2]), 32'h1);
    check("e26_ch2_out",  32'(clk_out[2]), 32'h0);
    check("e26_pending",  32'(pending), 32'h4);
    cfg_valid = 1'b0;
    step(4);                                        // E30, ch0 cnt=2 out=1
    check("e30_ch0_out", 32'(clk_out[0]), 32'h1);
    en = 4'hE;
    step(1);                                        // E31
    check("e31_pending",  32'(pending), 32'h4);
    check("e31_ch2_tick", 32'(tick[2]), 32'h0);
    check("dis_ch0_out",  32'(clk_out[0]), 32'h0);
    check("dis_ch0_tick", 32'(tick[0]), 32'h0);
    step(1);                                        // E32 ch2 reload div=1
    check("e32_ch2_tick", 32'(tick[2]), 32'h1);
    check("e32_ch2_out",  32'(clk_out[2]), 32'h1);
    check("e32_pending",  32'(pending), 32'h0);

    // ch0 <- 0 while disabled: direct load.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    step(1);                                        // E33
    check("wr0_no_pending", 32'(pending[0]), 32'h0);
    check("dis_ch0_out2",   32'(clk_out[0]), 32'h0);
    cfg_valid = 1'b0;
    step(1);                                        // E34
    check("e34_ch2_tick", 32'(tick[2]), 32'h1);
    check("e34_ch2_out",  32'(clk_out[2]), 32'h0);
    en = 4'hF;
    step(1);  check("re_e35_out",  32'(clk_out[0]), 32'h1);
              check("re_e35_tick", 32'(tick[0]),    32'h1);
    step(1);  check("re_e36_out",  32'(clk_out[0]), 32'h0);
              check("re_e36_tick", 32'(tick[0]),    32'h1);
    step(1);  check("re_e37_out",  32'(clk_out[0]), 32'h1);
              check("re_e37_tick", 32'(tick[0]),    32'h1);

    // ch3 pending + high, then async reset mid-cycle.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd6;
    step(1);                                        // E38
    check("wr3_pending", 32'(pending), 32'h8);
    check("wr3_out",     32'(clk_out[3]), 32'h1);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk_out", 32'(clk_out), 32'h0);
    check("arst_tick",    32'(tick),    32'h0);
    check("arst_pending", 32'(pending), 32'h0);
    check("arst_ready",   32'(cfg_ready), 32'h1);
    step(1);
    rst_n = 1'b1;                                   // R0
    step(3);  check("r3_clk_out", 32'(clk_out), 32'h0);
    step(1);  check("r4_clk_out", 32'(clk_out), 32'hF);
              check("r4_tick",    32'(tick),    32'hF);

    // Channels 0/1/2 at div 3/5/7, out of phase, then a sync pulse.
    en = 4'h0; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    step(1);                                        // T1
    cfg_ch = 2'd2; cfg_div = 8'd7;
    step(1);                                        // T2
    cfg_valid = 1'b0; en = 4'h1;
    step(2);                                        // T4
    en = 4'h3;
    step(1);                                        // T5
    en = 4'h7;
    step(1);                                        // T6
    check("t6_clk_out", 32'(clk_out), 32'h1);
    sync = 1'b1;
    step(1);                                        // T7 = S
    sync = 1'b0;
    check("s0_clk_out", 32'(clk_out), SYNC_ON ? 32'h0 : 32'h1);
    check("s0_tick",    32'(tick),    32'h0);
    step(3);                                        // S+3
    check("s3_clk_out", 32'(clk_out), SYNC_ON ? 32'h0 : 32'h2);
    check("s3_tick",    32'(tick),    SYNC_ON ? 32'h0 : 32'h3);
    step(1);                                        // S+4
    check("s4_clk_out", 32'(clk_out), SYNC_ON ? 32'h1 : 32'h2);
    check("s4_tick",    32'(tick),    SYNC_ON ? 32'h1 : 32'h0);
    step(2);                                        // S+6
    check("s6_clk_out", 32'(clk_out), SYNC_ON ? 32'h3 : 32'h6);
    check("s6_tick",    32'(tick),    SYNC_ON ? 32'h2 : 32'h4);
    step(2);                                        // S+8
    check("s8_clk_out", 32'(clk_out), SYNC_ON ? 32'h6 : 32'h7);
    check("s8_tick",    32'(tick),    SYNC_ON ? 32'h5 : 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
